// File: rtl/dsram_ctrl_if.sv
// AXI4-Lite bus between the data-SRAM sequencing controller and the SRAM slave.
// The controller takes the master modport; the SRAM model takes the slave modport.
interface dsram_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 8
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/dsram_ctrl.sv
// Data-SRAM sequencing controller: one memory micro-op at a time over AXI4-Lite,
// load alignment/extension, non-memory bypass and a per-state hang watchdog.
module dsram_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = 8,
    parameter int TIMEOUT     = 1023,
    parameter int INST_TYPE_W = 3,
    parameter int LSU_OP_W    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_pre_i,
    output logic                   ready_pre_o,
    input  logic [INST_TYPE_W-1:0] inst_type_i,
    input  logic [LSU_OP_W-1:0]    lsu_op_i,
    input  logic [ADDR_W-1:0]      araddr_i,
    input  logic [ADDR_W-1:0]      roff_i,
    input  logic [ADDR_W-1:0]      awaddr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [STRB_W-1:0]      wstrb_i,
    input  logic [DATA_W-1:0]      alu_result_i,
    dsram_ctrl_if.master           axi,
    output logic                   valid_post_o,
    input  logic                   ready_post_i,
    output logic [DATA_W-1:0]      result_o,
    output logic                   err_o
);
    localparam logic [INST_TYPE_W-1:0] INST_LOAD  = INST_TYPE_W'(1);
    localparam logic [INST_TYPE_W-1:0] INST_STORE = INST_TYPE_W'(2);
    localparam logic [LSU_OP_W-1:0]    LSU_LB     = LSU_OP_W'(1);
    localparam logic [LSU_OP_W-1:0]    LSU_LH     = LSU_OP_W'(2);
    localparam logic [LSU_OP_W-1:0]    LSU_LBU    = LSU_OP_W'(4);
    localparam logic [LSU_OP_W-1:0]    LSU_LHU    = LSU_OP_W'(5);
    localparam int                     CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [LSU_OP_W-1:0] lsu_op_r, lsu_op_nxt_s;
    logic [1:0]          roff_r, roff_nxt_s;
    logic [ADDR_W-1:0]   araddr_r, araddr_nxt_s;
    logic                arvalid_r, arvalid_nxt_s;
    logic                rready_r, rready_nxt_s;
    logic [ADDR_W-1:0]   awaddr_r, awaddr_nxt_s;
    logic                awvalid_r, awvalid_nxt_s;
    logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
    logic [STRB_W-1:0]   wstrb_r, wstrb_nxt_s;
    logic                wvalid_r, wvalid_nxt_s;
    logic                bready_r, bready_nxt_s;
    logic                valid_post_r, valid_post_nxt_s;
    logic [DATA_W-1:0]   result_r, result_nxt_s;
    logic                err_r, err_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                timeout_s;
    logic                aw_done_s;
    logic                w_done_s;
    logic                unused_s;

    // Only the low two offset bits select a byte lane.
    assign unused_s = ^roff_i[ADDR_W-1:2];

    function automatic logic [DATA_W-1:0] load_ext(input logic [LSU_OP_W-1:0] op,
                                                   input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = v;
        case (op)
            LSU_LB:  r = {{(DATA_W-8){v[7]}}, v[7:0]};
            LSU_LBU: r = {{(DATA_W-8){1'b0}}, v[7:0]};
            LSU_LH:  r = {{(DATA_W-16){v[15]}}, v[15:0]};
            LSU_LHU: r = {{(DATA_W-16){1'b0}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT));
    assign aw_done_s = !awvalid_r || axi.awready;
    assign w_done_s  = !wvalid_r || axi.wready;

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_nxt_s      = state_r;
        lsu_op_nxt_s     = lsu_op_r;
        roff_nxt_s       = roff_r;
        araddr_nxt_s     = araddr_r;
        arvalid_nxt_s    = arvalid_r;
        rready_nxt_s     = rready_r;
        awaddr_nxt_s     = awaddr_r;
        awvalid_nxt_s    = awvalid_r;
        wdata_nxt_s      = wdata_r;
        wstrb_nxt_s      = wstrb_r;
        wvalid_nxt_s     = wvalid_r;
        bready_nxt_s     = bready_r;
        valid_post_nxt_s = valid_post_r;
        result_nxt_s     = result_r;
        err_nxt_s        = err_r;
        cnt_nxt_s        = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (valid_pre_i) begin
                    lsu_op_nxt_s = lsu_op_i;
                    roff_nxt_s   = roff_i[1:0];
                    if (inst_type_i == INST_LOAD) begin
                        araddr_nxt_s  = araddr_i;
                        arvalid_nxt_s = 1'b1;
                        state_nxt_s   = ST_RD_ADDR;
                    end else if (inst_type_i == INST_STORE) begin
                        awaddr_nxt_s  = awaddr_i;
                        wdata_nxt_s   = wdata_i << {awaddr_i[1:0], 3'b000};
                        wstrb_nxt_s   = wstrb_i;
                        awvalid_nxt_s = 1'b1;
                        wvalid_nxt_s  = 1'b1;
                        state_nxt_s   = ST_WR_REQ;
                    end else begin
                        result_nxt_s     = alu_result_i;
                        valid_post_nxt_s = 1'b1;
                        state_nxt_s      = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (axi.arready) begin
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                    state_nxt_s   = ST_RD_DATA;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RD_DATA: begin
                if (axi.rvalid) begin
                    rready_nxt_s     = 1'b0;
                    result_nxt_s     = load_ext(lsu_op_r, axi.rdata >> {roff_r, 3'b000});
                    err_nxt_s        = err_r || (axi.rresp != 2'b00);
                    valid_post_nxt_s = 1'b1;
                    state_nxt_s      = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WR_REQ: begin
                awvalid_nxt_s = awvalid_r && !axi.awready;
                wvalid_nxt_s  = wvalid_r && !axi.wready;
                if (aw_done_s && w_done_s) begin
                    bready_nxt_s = 1'b1;
                    state_nxt_s  = ST_WR_RESP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WR_RESP: begin
                if (axi.bvalid) begin
                    bready_nxt_s     = 1'b0;
                    result_nxt_s     = {DATA_W{1'b0}};
                    err_nxt_s        = err_r || (axi.bresp != 2'b00);
                    valid_post_nxt_s = 1'b1;
                    state_nxt_s      = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (ready_post_i) begin
                    valid_post_nxt_s = 1'b0;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                arvalid_nxt_s    = 1'b0;
                rready_nxt_s     = 1'b0;
                awvalid_nxt_s    = 1'b0;
                wvalid_nxt_s     = 1'b0;
                bready_nxt_s     = 1'b0;
                valid_post_nxt_s = 1'b0;
                state_nxt_s      = ST_IDLE;
            end
        endcase

        // Watchdog abort only when the wait state made no progress this cycle.
        if (timeout_s && (state_nxt_s == state_r) &&
            (state_r inside {ST_RD_ADDR, ST_RD_DATA, ST_WR_REQ, ST_WR_RESP})) begin
            arvalid_nxt_s    = 1'b0;
            rready_nxt_s     = 1'b0;
            awvalid_nxt_s    = 1'b0;
            wvalid_nxt_s     = 1'b0;
            bready_nxt_s     = 1'b0;
            result_nxt_s     = {DATA_W{1'b0}};
            err_nxt_s        = 1'b1;
            valid_post_nxt_s = 1'b1;
            state_nxt_s      = ST_DONE;
        end else begin
            err_nxt_s = err_nxt_s;
        end

        if (state_nxt_s != state_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_nxt_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            lsu_op_r     <= {LSU_OP_W{1'b0}};
            roff_r       <= 2'b00;
            araddr_r     <= {ADDR_W{1'b0}};
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awaddr_r     <= {ADDR_W{1'b0}};
            awvalid_r    <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
            wstrb_r      <= {STRB_W{1'b0}};
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            valid_post_r <= 1'b0;
            result_r     <= {DATA_W{1'b0}};
            err_r        <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            lsu_op_r     <= lsu_op_nxt_s;
            roff_r       <= roff_nxt_s;
            araddr_r     <= araddr_nxt_s;
            arvalid_r    <= arvalid_nxt_s;
            rready_r     <= rready_nxt_s;
            awaddr_r     <= awaddr_nxt_s;
            awvalid_r    <= awvalid_nxt_s;
            wdata_r      <= wdata_nxt_s;
            wstrb_r      <= wstrb_nxt_s;
            wvalid_r     <= wvalid_nxt_s;
            bready_r     <= bready_nxt_s;
            valid_post_r <= valid_post_nxt_s;
            result_r     <= result_nxt_s;
            err_r        <= err_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    // ready_pre is a pure decode of the state register, so it is high straight out of reset.
    assign ready_pre_o  = (state_r == ST_IDLE);
    assign axi.araddr   = araddr_r;
    assign axi.arvalid  = arvalid_r;
    assign axi.rready   = rready_r;
    assign axi.awaddr   = awaddr_r;
    assign axi.awvalid  = awvalid_r;
    assign axi.wdata    = wdata_r;
    assign axi.wstrb    = wstrb_r;
    assign axi.wvalid   = wvalid_r;
    assign axi.bready   = bready_r;
    assign valid_post_o = valid_post_r;
    assign result_o     = result_r;
    assign err_o        = err_r;
endmodule

// File: tb/tb_dsram_ctrl.sv
// Directed self-checking bench for dsram_ctrl; the bench plays the SRAM slave by hand.
module tb_dsram_ctrl;
    localparam int TMO = 20;
    localparam logic [2:0] I_OTHER = 3'd0;
    localparam logic [2:0] I_LOAD  = 3'd1;
    localparam logic [2:0] I_STORE = 3'd2;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_pre_i;
    logic        ready_pre_o;
    logic [2:0]  inst_type_i;
    logic [3:0]  lsu_op_i;
    logic [31:0] araddr_i, roff_i, awaddr_i, wdata_i, alu_result_i;
    logic [7:0]  wstrb_i;
    logic        valid_post_o;
    logic        ready_post_i;
    logic [31:0] result_o;
    logic        err_o;
    int          checks = 0;
    int          failures = 0;

    dsram_ctrl_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) axi_bus ();

    dsram_ctrl #(.ADDR_W(32), .DATA_W(32), .STRB_W(8), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_pre_i  (valid_pre_i),
        .ready_pre_o  (ready_pre_o),
        .inst_type_i  (inst_type_i),
        .lsu_op_i     (lsu_op_i),
        .araddr_i     (araddr_i),
        .roff_i       (roff_i),
        .awaddr_i     (awaddr_i),
        .wdata_i      (wdata_i),
        .wstrb_i      (wstrb_i),
        .alu_result_i (alu_result_i),
        .axi          (axi_bus),
        .valid_post_o (valid_post_o),
        .ready_post_i (ready_post_i),
        .result_o     (result_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] it, input logic [3:0] op, input logic [31:0] ara,
                         input logic [31:0] ro, input logic [31:0] awa, input logic [31:0] wd,
                         input logic [7:0] ws, input logic [31:0] alu);
        int n;
        inst_type_i = it; lsu_op_i = op; araddr_i = ara; roff_i = ro;
        awaddr_i = awa; wdata_i = wd; wstrb_i = ws; alu_result_i = alu;
        valid_pre_i = 1'b1;
        n = 0;
        while (!ready_pre_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, ready_pre_o}, 32'd1);
        @(negedge clk);
        valid_pre_i = 1'b0;
    endtask

    // Full load with hand-timed AR and R delays; returns at the DONE cycle after checking it.
    task automatic load_seq(input string tag, input logic [3:0] op, input logic [31:0] ara,
                            input logic [31:0] ro, input logic [31:0] rd, input logic [1:0] rr,
                            input int ar_dly, input int r_dly, input logic [31:0] exp);
        issue(I_LOAD, op, ara, ro, 32'd0, 32'd0, 8'd0, 32'd0);
        check({tag, "_arvalid"}, {31'd0, axi_bus.arvalid}, 32'd1);
        check({tag, "_araddr"}, axi_bus.araddr, ara);
        repeat (ar_dly) @(negedge clk);
        axi_bus.arready = 1'b1;
        @(negedge clk);
        axi_bus.arready = 1'b0;
        check({tag, "_ar_drop"}, {30'd0, axi_bus.arvalid, axi_bus.rready}, 32'd1);
        repeat (r_dly) @(negedge clk);
        axi_bus.rdata = rd; axi_bus.rresp = rr; axi_bus.rvalid = 1'b1;
        @(negedge clk);
        axi_bus.rvalid = 1'b0; axi_bus.rresp = 2'b00;
        check({tag, "_vpost"}, {30'd0, valid_post_o, axi_bus.rready}, 32'd2);
        check({tag, "_result"}, result_o, exp);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        rst = 1'b1; valid_pre_i = 1'b0; ready_post_i = 1'b1;
        inst_type_i = 3'd0; lsu_op_i = 4'd0; araddr_i = 32'd0; roff_i = 32'd0;
        awaddr_i = 32'd0; wdata_i = 32'd0; wstrb_i = 8'd0; alu_result_i = 32'd0;
        axi_bus.arready = 1'b0; axi_bus.rdata = 32'd0; axi_bus.rresp = 2'b00;
        axi_bus.rvalid = 1'b0; axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        axi_bus.bresp = 2'b00; axi_bus.bvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready_pre", {31'd0, ready_pre_o}, 32'd1);
        check("rst_valids", {26'd0, axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid,
                             axi_bus.wvalid, axi_bus.bready, valid_post_o}, 32'd0);
        check("rst_result_err", result_o | {31'd0, err_o}, 32'd0);

        // Non-memory op: DONE one cycle after accept.
        issue(I_OTHER, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0, 32'h1234_5678);
        check("alu_vpost", {31'd0, valid_post_o}, 32'd1);
        check("alu_result", result_o, 32'h1234_5678);
        check("alu_no_axi", {30'd0, axi_bus.arvalid, axi_bus.awvalid}, 32'd0);
        @(negedge clk);
        check("alu_hs_idle", {30'd0, valid_post_o, ready_pre_o}, 32'd1);

        // Loads with alignment and extension.
        load_seq("lb", OP_LB, 32'h8000_0003, 32'd3, 32'h80FF_FFFF, 2'b00, 2, 2, 32'hFFFF_FF80);
        @(negedge clk);
        load_seq("lbu", OP_LBU, 32'h8000_0003, 32'd3, 32'h80FF_FFFF, 2'b00, 2, 2, 32'h0000_0080);
        @(negedge clk);
        load_seq("lh", OP_LH, 32'h8000_0002, 32'd2, 32'h80FF_FFFF, 2'b00, 2, 2, 32'hFFFF_80FF);
        @(negedge clk);
        load_seq("lhu", OP_LHU, 32'h8000_0000, 32'd0, 32'h1234_8001, 2'b00, 0, 0, 32'h0000_8001);
        @(negedge clk);
        load_seq("lw", OP_LW, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 2'b00, 0, 0, 32'hDEAD_BEEF);
        check("lw_err_clear", {31'd0, err_o}, 32'd0);
        @(negedge clk);

        // SH store: W handshakes three cycles ahead of AW.
        issue(I_STORE, OP_SH, 32'd0, 32'd0, 32'h8000_0002, 32'h0000_BEEF, 8'h0C, 32'd0);
        check("sh_valids", {30'd0, axi_bus.awvalid, axi_bus.wvalid}, 32'd3);
        check("sh_wdata", axi_bus.wdata, 32'hBEEF_0000);
        check("sh_wstrb", {24'd0, axi_bus.wstrb}, 32'h0000_000C);
        check("sh_awaddr", axi_bus.awaddr, 32'h8000_0002);
        axi_bus.wready = 1'b1;
        @(negedge clk);
        axi_bus.wready = 1'b0;
        check("sh_w_drop", {30'd0, axi_bus.awvalid, axi_bus.wvalid}, 32'd2);
        repeat (2) @(negedge clk);
        check("sh_aw_wait", {30'd0, axi_bus.awvalid, axi_bus.bready}, 32'd2);
        axi_bus.awready = 1'b1;
        @(negedge clk);
        axi_bus.awready = 1'b0;
        check("sh_bready", {29'd0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 32'd1);
        axi_bus.bvalid = 1'b1;
        @(negedge clk);
        axi_bus.bvalid = 1'b0;
        check("sh_done", {29'd0, valid_post_o, axi_bus.bready, err_o}, 32'd4);
        check("sh_result", result_o, 32'd0);
        @(negedge clk);

        // Watchdog: slave never returns R data.
        issue(I_LOAD, OP_LW, 32'h8000_0020, 32'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        axi_bus.arready = 1'b1;
        @(negedge clk);
        axi_bus.arready = 1'b0;
        check("tmo_err_before", {31'd0, err_o}, 32'd0);
        n = 0;
        while (axi_bus.rready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TMO + 1);
        check("tmo_flags", {29'd0, err_o, valid_post_o, axi_bus.rready}, 32'd6);
        check("tmo_result", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_err", {31'd0, err_o}, 32'd0);

        // SW store, AW and W together; B error must stick.
        issue(I_STORE, OP_SW, 32'd0, 32'd0, 32'h8000_0004, 32'hCAFE_F00D, 8'h0F, 32'd0);
        check("sw_wdata", axi_bus.wdata, 32'hCAFE_F00D);
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
        @(negedge clk);
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        check("sw_resp_next", {29'd0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 32'd1);
        axi_bus.bresp = 2'b10; axi_bus.bvalid = 1'b1;
        @(negedge clk);
        axi_bus.bvalid = 1'b0; axi_bus.bresp = 2'b00;
        check("sw_err", {30'd0, valid_post_o, err_o}, 32'd3);
        @(negedge clk);
        issue(I_OTHER, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0, 32'h0000_0042);
        check("err_sticky", {31'd0, err_o}, 32'd1);
        check("err_alu_result", result_o, 32'h0000_0042);
        @(negedge clk);

        // Reset in the middle of WR_REQ.
        issue(I_STORE, OP_SW, 32'd0, 32'd0, 32'h8000_0008, 32'h5555_AAAA, 8'h0F, 32'd0);
        check("mid_awvalid", {31'd0, axi_bus.awvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valids", {27'd0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready,
                                 valid_post_o, err_o}, 32'd0);
        check("mid_rst_data", axi_bus.wdata | axi_bus.awaddr | {24'd0, axi_bus.wstrb}, 32'd0);
        check("mid_rst_ready", {31'd0, ready_pre_o}, 32'd1);
        load_seq("post_rst", OP_LBU, 32'h8000_0001, 32'd1, 32'h0000_7F00, 2'b00, 1, 1, 32'h0000_007F);
        @(negedge clk);

        // Backpressure in DONE; a waiting micro-op must not be taken early.
        ready_post_i = 1'b0;
        issue(I_OTHER, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0, 32'hA5A5_0001);
        held = 32'hA5A5_0001;
        inst_type_i = I_OTHER; alu_result_i = 32'h0BAD_0002; valid_pre_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_stable", {30'd0, valid_post_o, ready_pre_o}, 32'd2);
            check("bp_result", result_o, held);
            @(negedge clk);
        end
        ready_post_i = 1'b1;
        @(negedge clk);
        check("bp_released", {30'd0, valid_post_o, ready_pre_o}, 32'd1);
        @(negedge clk);
        valid_pre_i = 1'b0;
        check("bp_next_op", result_o, 32'h0BAD_0002);
        @(negedge clk);

        // R error: data still delivered, err raised.
        load_seq("rerr", OP_LW, 32'h8000_0030, 32'd0, 32'h0101_0202, 2'b10, 0, 0, 32'h0101_0202);
        check("rerr_err", {31'd0, err_o}, 32'd1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
